spi_slave_param: RTL and testbench
==================================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the address/data payload width W; the frame length SHALL be W+2 bits (2 command bits plus payload).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-high (asserted = 1) despite the name; SHALL take effect only on a rising clk edge.
REQ-004 SS_n  input  1  slave select, active-low; high frames the end of a transaction.
REQ-005 MOSI  input  1  serial data in, MSB first, sampled on every rising clk edge while SS_n=0.
REQ-006 tx_data  input  W  read data from memory, valid when tx_valid=1.
REQ-007 tx_valid  input  1  qualifies tx_data; sampled only in READ_DATA after the frame has been received.
REQ-008 MISO  output  1  serial data out, MSB first.
REQ-009 rx_data  output  W+2  last received frame: {cmd[1:0], payload[W-1:0]}.
REQ-010 rx_valid  output  1  one-cycle pulse marking a newly completed rx_data.

Function
REQ-011 States SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; any unused encoding SHALL go to IDLE.
REQ-012 IDLE: SS_n=0 -> CHK_CMD; else stay.
REQ-013 CHK_CMD: SS_n=1 -> IDLE; MOSI=0 -> WRITE; MOSI=1 and read_flag=0 -> READ_ADD; MOSI=1 and read_flag=1 -> READ_DATA.
REQ-014 The MOSI bit sampled in CHK_CMD SHALL be frame bit W+1 and SHALL be shifted into the receive register; the remaining W+1 bits SHALL be shifted in the following W+1 cycles in WRITE/READ_ADD/READ_DATA.
REQ-015 A bit counter SHALL count received bits; on the edge sampling bit 0 (count reaching W+2), rx_data SHALL load the full frame, and rx_valid SHALL be 1 for exactly the following cycle.
REQ-016 MOSI bits beyond W+2 within the same SS_n-low window SHALL be ignored; rx_data SHALL hold until the next completed frame.
REQ-017 WRITE, READ_ADD, READ_DATA: SS_n=1 -> IDLE; else stay.
REQ-018 read_flag SHALL set to 1 when a READ_ADD frame completes, and clear to 0 when a READ_DATA transaction completes its MISO shift-out.
REQ-019 READ_DATA, after frame completion: the first cycle with tx_valid=1 SHALL latch tx_data; MISO SHALL then present bits W-1..0 on the next W consecutive cycles, one per cycle.
REQ-020 tx_valid SHALL be ignored outside READ_DATA, before frame completion, and during or after shift-out.
REQ-021 MISO SHALL be 0 whenever no shift-out is in progress.
REQ-022 SS_n=1 mid-frame or mid-shift-out SHALL return to IDLE next cycle, discard the partial frame (no rx_valid), force MISO to 0, and leave read_flag unchanged.
REQ-023 The bit counter width SHALL be clog2(W+3); W=1 SHALL be legal.

Reset
REQ-024 With rst_n=1 at a clk edge: state=IDLE, read_flag=0, counters=0, rx_data=0, rx_valid=0, MISO=0, overriding every other input, including mid-frame and mid-shift-out.
REQ-025 After rst_n returns to 0, a new transaction SHALL require SS_n to be sampled 0 from IDLE.

Verification (W=8 unless stated)
REQ-026 Write address: SS_n=0, MOSI 00_1010_0101 over 10 cycles -> rx_data=10'h0A5, rx_valid high exactly 1 cycle, state WRITE until SS_n=1.
REQ-027 Read pair: frame 10_0000_1111 -> rx_data=10'h20F, read_flag=1; SS_n=1 then 0; frame 11_xxxx_xxxx -> READ_DATA; tx_valid=1 with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1, then 0; read_flag=0.
REQ-028 Read with read_flag=0: frame starting with 1 -> READ_ADD entered, not READ_DATA.
REQ-029 Abort: SS_n=1 after 5 bits -> IDLE next cycle, no rx_valid, rx_data unchanged.
REQ-030 rst_n=1 during the MISO shift-out at bit 4 -> next cycle MISO=0, IDLE, read_flag=0, rx_valid=0.
REQ-031 ADDR_WIDTH=4 instance: 6-bit frame 01_1001 -> rx_data=6'h19, rx_valid on the cycle after the 6th bit.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave with a parameterised payload width.
// A frame is W+2 bits, MSB first: two command bits followed by a W-bit payload.
// The first command bit picks the path: 0 -> WRITE, 1 -> READ_ADD or READ_DATA
// depending on whether a read address has already been captured (read_flag).
// In READ_DATA, once the frame is in, the first tx_valid latches tx_data and
// MISO shifts it out MSB first over the next W cycles.
module spi_slave_param #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,     // synchronous, active-high despite the name
    input  logic                  SS_n,
    input  logic                  MOSI,
    input  logic [ADDR_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  MISO,
    output logic [ADDR_WIDTH+1:0] rx_data,
    output logic                  rx_valid
);

    localparam int W  = ADDR_WIDTH;
    localparam int FW = W + 2;
    localparam int CW = $clog2(W + 3);

    // Bit counter values: last frame bit being sampled, frame complete, shift-out length.
    localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);
    localparam logic [CW-1:0] FULL     = CW'(FW);
    localparam logic [CW-1:0] TX_LEN   = CW'(W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;          // received bits in this frame, saturates at FULL
    logic [FW-1:0]   sr_q, sr_d;            // receive shift register
    logic [FW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            read_flag_q, read_flag_d;
    logic [W-1:0]    tx_sr_q, tx_sr_d;      // remaining bits to send, MSB aligned
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;    // bits already placed on MISO
    logic            shifting_q, shifting_d;
    logic            tx_done_q, tx_done_d;  // blocks a second latch within one transaction
    logic            miso_q, miso_d;

    logic            sample;
    logic            frame_done;

    // A bit is taken only while selected, past IDLE, and before the frame is full;
    // anything beyond W+2 bits in the same select window falls on the floor.
    assign sample     = (state_q != IDLE) && !SS_n && (cnt_q != FULL);
    assign frame_done = sample && (cnt_q == LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; SS_n high from any active state drops back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)             state_d = IDLE;
                else if (!MOSI)       state_d = WRITE;
                else if (read_flag_q) state_d = READ_DATA;
                else                  state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive path, read_flag bookkeeping and MISO shift-out.
    always_comb begin
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        read_flag_d = read_flag_q;
        tx_sr_d     = tx_sr_q;
        tx_cnt_d    = tx_cnt_q;
        shifting_d  = shifting_q;
        tx_done_d   = tx_done_q;
        miso_d      = miso_q;

        if (state_q == IDLE || SS_n) begin
            // Between transactions or on deselect: drop any partial frame or
            // shift-out; read_flag deliberately survives an abort.
            cnt_d      = '0;
            tx_cnt_d   = '0;
            shifting_d = 1'b0;
            tx_done_d  = 1'b0;
            miso_d     = 1'b0;
        end else begin
            if (sample) begin
                sr_d  = {sr_q[FW-2:0], MOSI};
                cnt_d = cnt_q + CW'(1);
            end

            if (frame_done) begin
                rx_data_d  = {sr_q[FW-2:0], MOSI};
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD) read_flag_d = 1'b1;
            end

            if (state_q == READ_DATA) begin
                if (shifting_q) begin
                    if (tx_cnt_q == TX_LEN) begin
                        miso_d      = 1'b0;
                        shifting_d  = 1'b0;
                        tx_done_d   = 1'b1;
                        read_flag_d = 1'b0;
                    end else begin
                        miso_d   = tx_sr_q[W-1];
                        tx_sr_d  = tx_sr_q << 1;
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end else if (cnt_q == FULL && !tx_done_q && tx_valid) begin
                    // First bit goes out straight from tx_data; the rest follow from tx_sr.
                    miso_d     = tx_data[W-1];
                    tx_sr_d    = tx_data << 1;
                    tx_cnt_d   = CW'(1);
                    shifting_d = 1'b1;
                end
            end
        end
    end

    // Datapath registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q       <= '0;
            sr_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            read_flag_q <= 1'b0;
            tx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            shifting_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            read_flag_q <= read_flag_d;
            tx_sr_q     <= tx_sr_d;
            tx_cnt_q    <= tx_cnt_d;
            shifting_q  <= shifting_d;
            tx_done_q   <= tx_done_d;
            miso_q      <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: directed cases plus random transactions on a
// W=8 instance, and a short frame check on a W=4 instance. The reference
// model tracks the transaction-level rules only: last completed frame and
// whether a read address is pending.
module tb_spi_slave_param;

    logic       clk;
    logic       rst;
    logic       ss, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;

    logic       ss4, mosi4, txv4;
    logic [3:0] txd4;
    logic       miso4;
    logic [5:0] rxd4;
    logic       rxv4;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit         mflag = 1'b0;   // read address captured, next read frame returns data
    logic [9:0] mrx   = '0;     // last completed frame

    spi_slave_param #(.ADDR_WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst), .SS_n(ss), .MOSI(mosi),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    spi_slave_param #(.ADDR_WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst), .SS_n(ss4), .MOSI(mosi4),
        .tx_data(txd4), .tx_valid(txv4),
        .MISO(miso4), .rx_data(rxd4), .rx_valid(rxv4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One transaction on the W=8 instance.
    //   nbits  : frame bits sent before deselect (10 = full frame)
    //   nshift : MISO bit index at which SS_n is raised (8 = no abort)
    //   rst_at : MISO bit index at which reset is applied (-1 = never)
    task automatic txn8(input logic [9:0] f, input int nbits, input int nshift,
                        input int rst_at, input logic [7:0] d);
        int kind;
        int gap;
        kind = (f[9] == 1'b0) ? 0 : (mflag ? 2 : 1);   // 0 write, 1 read addr, 2 read data

        ss = 1'b0; mosi = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
        @(negedge clk);
        chk("idle_rxv", 32'(rx_valid), 0);

        for (int i = 0; i < nbits; i++) begin
            mosi = f[9-i]; tx_valid = 1'($urandom); tx_data = 8'($urandom);
            @(negedge clk);
            chk("rxv", 32'(rx_valid), 32'(i == 9));
            chk("miso_rx", 32'(MISO), 0);
        end

        if (nbits < 10) begin
            ss = 1'b1; tx_valid = 1'b0;
            @(negedge clk);
            chk("abort_rxv", 32'(rx_valid), 0);
            chk("abort_rxd", 32'(rx_data), 32'(mrx));
            chk("abort_miso", 32'(MISO), 0);
            return;
        end

        mrx = f;
        chk("rxd", 32'(rx_data), 32'(mrx));
        if (kind == 1) mflag = 1'b1;

        // Extra bit in the same window must be ignored.
        tx_valid = 1'b0; mosi = 1'($urandom);
        @(negedge clk);
        chk("extra_rxv", 32'(rx_valid), 0);
        chk("extra_rxd", 32'(rx_data), 32'(mrx));
        chk("extra_miso", 32'(MISO), 0);

        if (kind == 2) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                chk("wait_miso", 32'(MISO), 0);
            end
            tx_valid = 1'b1; tx_data = d;
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                chk("miso_bit", 32'(MISO), 32'(d[7-k]));
                tx_valid = 1'($urandom); tx_data = 8'($urandom);
                if (k == rst_at) begin
                    rst = 1'b1; ss = 1'b1;
                    @(negedge clk);
                    chk("rst_miso", 32'(MISO), 0);
                    chk("rst_rxv", 32'(rx_valid), 0);
                    chk("rst_rxd", 32'(rx_data), 0);
                    rst = 1'b0; tx_valid = 1'b0;
                    mflag = 1'b0; mrx = '0;
                    @(negedge clk);
                    chk("post_rst_miso", 32'(MISO), 0);
                    return;
                end
                if (k == nshift) begin
                    ss = 1'b1;
                    @(negedge clk);
                    chk("shabort_miso", 32'(MISO), 0);
                    chk("shabort_rxv", 32'(rx_valid), 0);
                    tx_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            chk("miso_end", 32'(MISO), 0);
            mflag = 1'b0;
            tx_valid = 1'b1; tx_data = 8'($urandom);
            repeat (2) begin
                @(negedge clk);
                chk("miso_post", 32'(MISO), 0);
            end
        end else begin
            tx_valid = 1'b1; tx_data = 8'($urandom);
            repeat (2) begin
                @(negedge clk);
                chk("miso_ign", 32'(MISO), 0);
            end
        end

        tx_valid = 1'b0; ss = 1'b1;
        @(negedge clk);
        chk("end_miso", 32'(MISO), 0);
        chk("end_rxv", 32'(rx_valid), 0);
    endtask

    initial begin
        logic [5:0] f4;
        rst = 1'b1; ss = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        ss4 = 1'b1; mosi4 = 1'b0; txv4 = 1'b0; txd4 = '0;
        repeat (2) @(negedge clk);
        chk("reset_miso", 32'(MISO), 0);
        chk("reset_rxd", 32'(rx_data), 0);
        chk("reset_rxv", 32'(rx_valid), 0);
        chk("reset_rxd4", 32'(rxd4), 0);
        chk("reset_miso4", 32'(miso4), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write address frame.
        txn8(10'b00_1010_0101, 10, 8, -1, 8'h00);
        chk("write_rxd", 32'(rx_data), 32'h0A5);

        // Read address then read data returning C3.
        txn8(10'b10_0000_1111, 10, 8, -1, 8'h00);
        chk("rdaddr_rxd", 32'(rx_data), 32'h20F);
        txn8({2'b11, 8'($urandom)}, 10, 8, -1, 8'hC3);

        // With no pending address a read frame is an address phase: tx_valid ignored.
        txn8({2'b11, 8'($urandom)}, 10, 8, -1, 8'h00);

        // Abort after five bits.
        txn8(10'b00_1111_0000, 5, 8, -1, 8'h00);

        // Random transactions, including partial frames and shift-out aborts.
        for (int n = 0; n < 40; n++) begin
            int nb, ns;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
            ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 8;
            txn8(10'($urandom), nb, ns, -1, 8'($urandom));
        end

        // Reset during shift-out: make sure a read address is pending first.
        if (!mflag) txn8({2'b10, 8'($urandom)}, 10, 8, -1, 8'h00);
        txn8({2'b11, 8'($urandom)}, 10, 8, 3, 8'h5A);
        // read_flag must have been cleared: this read frame is an address phase.
        txn8({2'b11, 8'($urandom)}, 10, 8, -1, 8'h00);
        txn8({2'b11, 8'($urandom)}, 10, 8, -1, 8'h96);

        // Narrow instance: 6-bit frame.
        f4 = 6'b01_1001;
        ss4 = 1'b0;
        @(negedge clk);
        for (int i = 5; i >= 0; i--) begin
            mosi4 = f4[i];
            @(negedge clk);
            chk("w4_rxv", 32'(rxv4), 32'(i == 0));
        end
        chk("w4_rxd", 32'(rxd4), 32'h19);
        mosi4 = 1'b1;
        @(negedge clk);
        chk("w4_rxv_after", 32'(rxv4), 0);
        chk("w4_rxd_hold", 32'(rxd4), 32'h19);
        ss4 = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
